// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution PE, its feeder and its output collector.
package conv_pkg;

    localparam int KERNEL_TAPS = 9;
    localparam int W_AW        = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_W,
        STREAM,
        FLUSH
    } feeder_state_t;

endpackage

// File: rtl/raster_counter.sv
// Column/row raster walker producing a running linear address and terminal flags.
module raster_counter #(
    parameter int IMG_W = 10,
    parameter int IMG_H = 10,
    parameter int AW    = $clog2(IMG_W*IMG_H),
    parameter int CW    = $clog2(IMG_W),
    parameter int RW    = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          en,
    output logic [AW-1:0] addr,
    output logic          col_last,
    output logic          row_last,
    output logic          frame_last
);

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    assign col_last   = (col == CW'(IMG_W-1));
    assign row_last   = (row == RW'(IMG_H-1));
    assign frame_last = col_last & row_last;

    // Linear address advances alongside col/row so no multiplier is needed.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (en) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
            addr <= frame_last ? '0 : addr + AW'(1);
        end
    end

endmodule

// File: rtl/conv_pe_feeder.sv
// Reads nine kernel weights and then one image frame, streaming both to the PE.
module conv_pe_feeder
    import conv_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int IMG_W = 10,
    parameter int IMG_H = 10,
    parameter int PX_AW = $clog2(IMG_W*IMG_H)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    output logic             w_rd,
    output logic [3:0]       w_addr,
    input  logic [WIDTH-1:0] w_rdata,
    output logic             px_rd,
    output logic [PX_AW-1:0] px_addr,
    input  logic [WIDTH-1:0] px_rdata,
    output logic [WIDTH-1:0] weight_out,
    output logic             weight_valid,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             line_end,
    output logic             frame_end,
    output logic             busy,
    output logic             done
);

    feeder_state_t   state, state_next;
    logic [W_AW-1:0] w_cnt;
    logic            w_last;
    logic            col_last, row_last, frame_last;

    assign w_last = (w_cnt == W_AW'(KERNEL_TAPS-1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        w_rd       = 1'b0;
        px_rd      = 1'b0;
        case (state)
            IDLE:   if (start) state_next = LOAD_W;
            LOAD_W: if (!pause) begin
                w_rd = 1'b1;
                if (w_last) state_next = STREAM;
            end
            STREAM: if (!pause) begin
                px_rd = 1'b1;
                if (frame_last) state_next = FLUSH;
            end
            FLUSH:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)         w_cnt <= '0;
        else if (w_rd)   w_cnt <= w_last ? '0 : w_cnt + W_AW'(1);
    end

    raster_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .AW    (PX_AW)
    ) u_raster (
        .clk        (clk),
        .rst        (rst),
        .clear      (state == IDLE),
        .en         (px_rd),
        .addr       (px_addr),
        .col_last   (col_last),
        .row_last   (row_last),
        .frame_last (frame_last)
    );

    // Qualifiers and position flags line up with the buffer's one-cycle read return.
    always_ff @(posedge clk) begin
        if (rst) begin
            weight_valid <= 1'b0;
            data_valid   <= 1'b0;
            line_end     <= 1'b0;
            frame_end    <= 1'b0;
            done         <= 1'b0;
        end else begin
            weight_valid <= w_rd;
            data_valid   <= px_rd;
            line_end     <= px_rd & col_last;
            frame_end    <= px_rd & frame_last;
            done         <= (state == FLUSH);
        end
    end

    assign w_addr     = w_cnt;
    assign weight_out = weight_valid ? w_rdata  : '0;
    assign data_out   = data_valid   ? px_rdata : '0;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_conv_pe_feeder.sv
// Directed bench for conv_pe_feeder: a 4x4 instance for the main scenarios, a 3x3 one for minimum size.
module tb_conv_pe_feeder;

    localparam int WIDTH = 9;

    logic clk = 1'b0;
    logic rst, start, pause;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] wmem [0:8];

    logic             w_rd, px_rd, weight_valid, data_valid, line_end, frame_end, busy, done;
    logic [3:0]       w_addr, px_addr;
    logic [WIDTH-1:0] w_rdata, px_rdata, weight_out, data_out;

    logic             s_w_rd, s_px_rd, s_weight_valid, s_data_valid, s_line_end, s_frame_end, s_busy, s_done;
    logic [3:0]       s_w_addr, s_px_addr;
    logic [WIDTH-1:0] s_w_rdata, s_px_rdata, s_weight_out, s_data_out;

    conv_pe_feeder #(.WIDTH(WIDTH), .IMG_W(4), .IMG_H(4)) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause),
        .w_rd(w_rd), .w_addr(w_addr), .w_rdata(w_rdata),
        .px_rd(px_rd), .px_addr(px_addr), .px_rdata(px_rdata),
        .weight_out(weight_out), .weight_valid(weight_valid),
        .data_out(data_out), .data_valid(data_valid),
        .line_end(line_end), .frame_end(frame_end), .busy(busy), .done(done)
    );

    conv_pe_feeder #(.WIDTH(WIDTH), .IMG_W(3), .IMG_H(3)) dut_small (
        .clk(clk), .rst(rst), .start(start), .pause(pause),
        .w_rd(s_w_rd), .w_addr(s_w_addr), .w_rdata(s_w_rdata),
        .px_rd(s_px_rd), .px_addr(s_px_addr), .px_rdata(s_px_rdata),
        .weight_out(s_weight_out), .weight_valid(s_weight_valid),
        .data_out(s_data_out), .data_valid(s_data_valid),
        .line_end(s_line_end), .frame_end(s_frame_end), .busy(s_busy), .done(s_done)
    );

    // Synchronous-read buffers: weights from wmem, pixels are address+100.
    always_ff @(posedge clk) begin
        if (w_rd)    w_rdata    <= wmem[w_addr];
        if (px_rd)   px_rdata   <= WIDTH'(px_addr) + 9'd100;
        if (s_w_rd)  s_w_rdata  <= wmem[s_w_addr];
        if (s_px_rd) s_px_rdata <= WIDTH'(s_px_addr) + 9'd100;
    end

    logic             c_wv [0:63], c_wrd [0:63], c_dv [0:63], c_le [0:63], c_fe [0:63];
    logic             c_busy [0:63], c_done [0:63], c_pxrd [0:63];
    logic [WIDTH-1:0] c_wo [0:63], c_do [0:63];
    logic [3:0]       c_waddr [0:63], c_pxaddr [0:63];
    logic             s_dv [0:63], s_le [0:63], s_fe [0:63], s_dn [0:63];
    logic [WIDTH-1:0] s_do [0:63];

    // Cycle c runs from edge E(c-1) to E(c); inputs are applied just after E(c-1), outputs sampled mid-cycle.
    task automatic applyStimulus(input logic [63:0] st, input logic [63:0] ps, input logic [63:0] rs, input int n);
        for (int c = 0; c <= n; c++) begin
            @(posedge clk);
            #1;
            start = st[c];
            pause = ps[c];
            rst   = rs[c];
            @(negedge clk);
            c_wv[c]     = weight_valid;
            c_wo[c]     = weight_out;
            c_wrd[c]    = w_rd;
            c_waddr[c]  = w_addr;
            c_dv[c]     = data_valid;
            c_do[c]     = data_out;
            c_le[c]     = line_end;
            c_fe[c]     = frame_end;
            c_busy[c]   = busy;
            c_done[c]   = done;
            c_pxrd[c]   = px_rd;
            c_pxaddr[c] = px_addr;
            s_dv[c]     = s_data_valid;
            s_do[c]     = s_data_out;
            s_le[c]     = s_line_end;
            s_fe[c]     = s_frame_end;
            s_dn[c]     = s_done;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        pause = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic test_reset();
        applyStimulus(64'h0, 64'h0, 64'h7, 3);
        for (int c = 2; c <= 3; c++) begin
            n_checks++;
            if ({c_wv[c], c_wo[c], c_wrd[c], c_waddr[c], c_dv[c], c_do[c], c_le[c], c_fe[c],
                 c_busy[c], c_done[c], c_pxrd[c], c_pxaddr[c]} !== 36'd0) begin
                n_fail++;
                $display("[TB] FAIL reset.outputs c=%0d got wv=%b wo=%0d wrd=%b wa=%0d dv=%b do=%0d le=%b fe=%b busy=%b done=%b pxrd=%b pxa=%0d exp all 0",
                         c, c_wv[c], c_wo[c], c_wrd[c], c_waddr[c], c_dv[c], c_do[c], c_le[c], c_fe[c],
                         c_busy[c], c_done[c], c_pxrd[c], c_pxaddr[c]);
            end
            n_checks++;
            if ({s_dv[c], s_do[c], s_le[c], s_fe[c], s_dn[c]} !== 13'd0) begin
                n_fail++;
                $display("[TB] FAIL reset.small c=%0d got dv=%b do=%0d exp 0", c, s_dv[c], s_do[c]);
            end
        end
    endtask

    task automatic test_basic();
        logic ewv, ewrd, edv, epx, ele, efe, ebusy, edone;
        int   ewo, edo;
        applyStimulus(64'h1, 64'h0, 64'h0, 30);
        for (int c = 0; c <= 30; c++) begin
            ewv   = (c >= 2 && c <= 10);
            ewo   = ewv ? c - 1 : 0;
            ewrd  = (c >= 1 && c <= 9);
            epx   = (c >= 10 && c <= 25);
            edv   = (c >= 11 && c <= 26);
            edo   = edv ? 100 + c - 11 : 0;
            ele   = edv && ((c - 11) % 4 == 3);
            efe   = (c == 26);
            ebusy = (c >= 1 && c <= 26);
            edone = (c == 27);
            n_checks++;
            if (c_wv[c] !== ewv || c_wo[c] !== 9'(ewo)) begin
                n_fail++;
                $display("[TB] FAIL basic.weight c=%0d got v=%b w=%0d exp v=%b w=%0d", c, c_wv[c], c_wo[c], ewv, ewo);
            end
            n_checks++;
            if (c_dv[c] !== edv || c_do[c] !== 9'(edo) || c_le[c] !== ele || c_fe[c] !== efe) begin
                n_fail++;
                $display("[TB] FAIL basic.data c=%0d got v=%b d=%0d le=%b fe=%b exp v=%b d=%0d le=%b fe=%b",
                         c, c_dv[c], c_do[c], c_le[c], c_fe[c], edv, edo, ele, efe);
            end
            n_checks++;
            if (c_busy[c] !== ebusy || c_done[c] !== edone) begin
                n_fail++;
                $display("[TB] FAIL basic.status c=%0d got busy=%b done=%b exp busy=%b done=%b", c, c_busy[c], c_done[c], ebusy, edone);
            end
            n_checks++;
            if (c_wrd[c] !== ewrd || (ewrd && c_waddr[c] !== 4'(c - 1))) begin
                n_fail++;
                $display("[TB] FAIL basic.w_addr c=%0d got rd=%b a=%0d exp rd=%b a=%0d", c, c_wrd[c], c_waddr[c], ewrd, c - 1);
            end
            n_checks++;
            if (c_pxrd[c] !== epx || (epx && c_pxaddr[c] !== 4'(c - 10))) begin
                n_fail++;
                $display("[TB] FAIL basic.px_addr c=%0d got rd=%b a=%0d exp rd=%b a=%0d", c, c_pxrd[c], c_pxaddr[c], epx, c - 10);
            end
        end
    endtask

    task automatic test_zero_weights();
        int ewo;
        wmem[2] = 9'd0;
        wmem[5] = 9'd0;
        applyStimulus(64'h1, 64'h0, 64'h0, 29);
        for (int c = 2; c <= 10; c++) begin
            ewo = (c == 4 || c == 7) ? 0 : c - 1;
            n_checks++;
            if (c_wv[c] !== 1'b1 || c_wo[c] !== 9'(ewo)) begin
                n_fail++;
                $display("[TB] FAIL zero_w.beat c=%0d got v=%b w=%0d exp v=1 w=%0d", c, c_wv[c], c_wo[c], ewo);
            end
        end
        wmem[2] = 9'd3;
        wmem[5] = 9'd6;
    endtask

    task automatic test_pause();
        logic ewv, edv, ele;
        int   ewo, edo;
        applyStimulus(64'h1, (64'h1 << 5) | (64'h1 << 6) | (64'h1 << 15), 64'h0, 32);
        for (int c = 0; c <= 32; c++) begin
            ewo = 0;
            edo = 0;
            if (c >= 2 && c <= 5)   ewo = c - 1;
            if (c >= 8 && c <= 12)  ewo = c - 3;
            if (c >= 13 && c <= 15) edo = 100 + c - 13;
            if (c >= 17 && c <= 29) edo = 100 + c - 14;
            ewv = (ewo != 0);
            edv = (edo != 0);
            ele = edv && ((edo - 100) % 4 == 3);
            n_checks++;
            if (c_wv[c] !== ewv || c_wo[c] !== 9'(ewo)) begin
                n_fail++;
                $display("[TB] FAIL pause.weight c=%0d got v=%b w=%0d exp v=%b w=%0d", c, c_wv[c], c_wo[c], ewv, ewo);
            end
            n_checks++;
            if (c_dv[c] !== edv || c_do[c] !== 9'(edo) || c_le[c] !== ele || c_fe[c] !== (c == 29)) begin
                n_fail++;
                $display("[TB] FAIL pause.data c=%0d got v=%b d=%0d le=%b fe=%b exp v=%b d=%0d le=%b",
                         c, c_dv[c], c_do[c], c_le[c], c_fe[c], edv, edo, ele);
            end
            n_checks++;
            if (c_done[c] !== (c == 30)) begin
                n_fail++;
                $display("[TB] FAIL pause.done c=%0d got %b exp %b", c, c_done[c], (c == 30));
            end
        end
    endtask

    task automatic test_back_to_back();
        int nw1, nd1, nw2, nd2, nd;
        nw1 = 0; nd1 = 0; nw2 = 0; nd2 = 0; nd = 0;
        applyStimulus(64'h1 | (64'h1 << 8) | (64'h1 << 27), 64'h0, 64'h0, 57);
        for (int c = 0; c <= 57; c++) begin
            if (c <= 27) begin
                nw1 += int'(c_wv[c]);
                nd1 += int'(c_dv[c]);
            end else begin
                nw2 += int'(c_wv[c]);
                nd2 += int'(c_dv[c]);
            end
            nd += int'(c_done[c]);
        end
        n_checks++;
        if (nw1 != 9 || nd1 != 16) begin
            n_fail++;
            $display("[TB] FAIL b2b.frame1_beats got w=%0d d=%0d exp w=9 d=16", nw1, nd1);
        end
        n_checks++;
        if (nw2 != 9 || nd2 != 16) begin
            n_fail++;
            $display("[TB] FAIL b2b.frame2_beats got w=%0d d=%0d exp w=9 d=16", nw2, nd2);
        end
        n_checks++;
        if (c_done[27] !== 1'b1 || c_done[54] !== 1'b1 || nd != 2) begin
            n_fail++;
            $display("[TB] FAIL b2b.done got d27=%b d54=%b count=%0d exp 1 1 2", c_done[27], c_done[54], nd);
        end
        n_checks++;
        if (c_wrd[28] !== 1'b1 || c_waddr[28] !== 4'd0) begin
            n_fail++;
            $display("[TB] FAIL b2b.restart got rd=%b a=%0d exp rd=1 a=0", c_wrd[28], c_waddr[28]);
        end
        n_checks++;
        if (c_wo[29] !== 9'd1 || c_do[38] !== 9'd100 || c_fe[53] !== 1'b1 || c_do[53] !== 9'd115) begin
            n_fail++;
            $display("[TB] FAIL b2b.frame2_data got w29=%0d d38=%0d fe53=%b d53=%0d exp 1 100 1 115",
                     c_wo[29], c_do[38], c_fe[53], c_do[53]);
        end
    endtask

    task automatic test_reset_mid_frame();
        applyStimulus(64'h1, 64'h0, 64'h1 << 14, 17);
        n_checks++;
        if (c_dv[14] !== 1'b1 || c_do[14] !== 9'd103) begin
            n_fail++;
            $display("[TB] FAIL rst_mid.pre c=14 got v=%b d=%0d exp v=1 d=103", c_dv[14], c_do[14]);
        end
        for (int c = 15; c <= 17; c++) begin
            n_checks++;
            if ({c_wv[c], c_wo[c], c_wrd[c], c_waddr[c], c_dv[c], c_do[c], c_le[c], c_fe[c],
                 c_busy[c], c_done[c], c_pxrd[c], c_pxaddr[c]} !== 36'd0) begin
                n_fail++;
                $display("[TB] FAIL rst_mid.outputs c=%0d got dv=%b do=%0d busy=%b pxrd=%b pxa=%0d done=%b exp all 0",
                         c, c_dv[c], c_do[c], c_busy[c], c_pxrd[c], c_pxaddr[c], c_done[c]);
            end
        end
        applyStimulus(64'h1, 64'h0, 64'h0, 28);
        n_checks++;
        if (c_wrd[1] !== 1'b1 || c_waddr[1] !== 4'd0 || c_wo[2] !== 9'd1 || c_wo[10] !== 9'd9) begin
            n_fail++;
            $display("[TB] FAIL rst_mid.rerun_w got rd1=%b a1=%0d w2=%0d w10=%0d exp 1 0 1 9",
                     c_wrd[1], c_waddr[1], c_wo[2], c_wo[10]);
        end
        n_checks++;
        if (c_do[11] !== 9'd100 || c_do[26] !== 9'd115 || c_fe[26] !== 1'b1 || c_done[27] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL rst_mid.rerun_d got d11=%0d d26=%0d fe26=%b done27=%b exp 100 115 1 1",
                     c_do[11], c_do[26], c_fe[26], c_done[27]);
        end
    endtask

    task automatic test_min_size();
        logic edv, ele;
        int   edo;
        applyStimulus(64'h1, 64'h0, 64'h0, 22);
        for (int c = 0; c <= 22; c++) begin
            edv = (c >= 11 && c <= 19);
            edo = edv ? 100 + c - 11 : 0;
            ele = (c == 13 || c == 16 || c == 19);
            n_checks++;
            if (s_dv[c] !== edv || s_do[c] !== 9'(edo) || s_le[c] !== ele || s_fe[c] !== (c == 19)) begin
                n_fail++;
                $display("[TB] FAIL min.data c=%0d got v=%b d=%0d le=%b fe=%b exp v=%b d=%0d le=%b fe=%b",
                         c, s_dv[c], s_do[c], s_le[c], s_fe[c], edv, edo, ele, (c == 19));
            end
            n_checks++;
            if (s_dn[c] !== (c == 20)) begin
                n_fail++;
                $display("[TB] FAIL min.done c=%0d got %b exp %b", c, s_dn[c], (c == 20));
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        pause = 1'b0;
        for (int i = 0; i < 9; i++) wmem[i] = 9'(i + 1);
        $display("[TB] conv_pe_feeder directed test start");
        test_reset();
        test_basic();
        test_zero_weights();
        test_pause();
        test_back_to_back();
        test_reset_mid_frame();
        test_min_size();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
